// File: rtl/vga_sync_640_480_if.sv
// rtl/vga_sync_640_480_if.sv - raster output bundle between the sync generator and its consumers
interface vga_sync_640_480_if;
  logic [9:0] o_hidx;
  logic [8:0] o_vidx;
  logic       o_haddr_enb;
  logic       o_vaddr_enb;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_frame_start;

  modport master (
    output o_hidx, o_vidx, o_haddr_enb, o_vaddr_enb,
    output o_hsync, o_vsync, o_frame_start
  );

  modport slave (
    input o_hidx, o_vidx, o_haddr_enb, o_vaddr_enb,
    input o_hsync, o_vsync, o_frame_start
  );
endinterface

// File: rtl/vga_sync_640_480.sv
// rtl/vga_sync_640_480.sv - 640x480@60 raster counters with registered coordinate, enable and sync decode
module vga_sync_640_480 #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic                  clk,
  input  logic                  i_sclr,
  input  logic                  i_px_clk,
  vga_sync_640_480_if.master    vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic [9:0] hidx_q, hidx_d;
  logic [8:0] vidx_q, vidx_d;
  logic       haddr_enb_q, haddr_enb_d;
  logic       vaddr_enb_q, vaddr_enb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    frame_start_d = 1'b0;
    if (i_px_clk) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = 10'd0;
        if (vcnt_q == V_LAST) begin
          vcnt_d        = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          vcnt_d = vcnt_q + 10'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // Decode the next-state counters so the registered outputs always match the counters they load with.
  always_comb begin
    haddr_enb_d = (hcnt_d < H_VIS);
    vaddr_enb_d = (vcnt_d < V_VIS);
    hidx_d      = haddr_enb_d ? hcnt_d : 10'd0;
    vidx_d      = vaddr_enb_d ? vcnt_d[8:0] : 9'd0;
    hsync_d     = ((hcnt_d >= HS_START) && (hcnt_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d     = ((vcnt_d >= VS_START) && (vcnt_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      hidx_q        <= 10'd0;
      vidx_q        <= 9'd0;
      haddr_enb_q   <= 1'b1;
      vaddr_enb_q   <= 1'b1;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hidx_q        <= hidx_d;
      vidx_q        <= vidx_d;
      haddr_enb_q   <= haddr_enb_d;
      vaddr_enb_q   <= vaddr_enb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.o_hidx        = hidx_q;
  assign vga.o_vidx        = vidx_q;
  assign vga.o_haddr_enb   = haddr_enb_q;
  assign vga.o_vaddr_enb   = vaddr_enb_q;
  assign vga.o_hsync       = hsync_q;
  assign vga.o_vsync       = vsync_q;
  assign vga.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_640_480.sv
// tb/tb_vga_sync_640_480.sv - self-checking bench for vga_sync_640_480
module tb_vga_sync_640_480;

  logic clk;
  logic sclr;
  logic px;
  logic chk_en;

  int n_vec;
  int n_err;

  // Three instances: default timing, a tiny raster for whole-frame checks, and inverted sync polarity.
  int hv_p [3] = '{640, 8, 640};
  int hf_p [3] = '{16, 2, 16};
  int hs_p [3] = '{96, 3, 96};
  int hb_p [3] = '{48, 3, 48};
  int vv_p [3] = '{480, 6, 480};
  int vf_p [3] = '{10, 2, 10};
  int vs_p [3] = '{2, 2, 2};
  int vb_p [3] = '{33, 3, 33};
  logic pol_p [3] = '{1'b0, 1'b0, 1'b1};

  vga_sync_640_480_if if0 ();
  vga_sync_640_480_if if1 ();
  vga_sync_640_480_if if2 ();

  vga_sync_640_480 u0 (.clk(clk), .i_sclr(sclr), .i_px_clk(px), .vga(if0));

  vga_sync_640_480 #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u1 (.clk(clk), .i_sclr(sclr), .i_px_clk(px), .vga(if1));

  vga_sync_640_480 #(.SYNC_POL(1'b1)) u2 (.clk(clk), .i_sclr(sclr), .i_px_clk(px), .vga(if2));

  logic [23:0] act [3];
  assign act[0] = {if0.o_hidx, if0.o_vidx, if0.o_haddr_enb, if0.o_vaddr_enb, if0.o_hsync, if0.o_vsync, if0.o_frame_start};
  assign act[1] = {if1.o_hidx, if1.o_vidx, if1.o_haddr_enb, if1.o_vaddr_enb, if1.o_hsync, if1.o_vsync, if1.o_frame_start};
  assign act[2] = {if2.o_hidx, if2.o_vidx, if2.o_haddr_enb, if2.o_vaddr_enb, if2.o_hsync, if2.o_vsync, if2.o_frame_start};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: a plain tick count since reset; position is derived by division.
  int   ticks;
  logic ticked;

  always @(posedge clk or posedge sclr) begin
    if (sclr) begin
      ticks  <= 0;
      ticked <= 1'b0;
    end else begin
      ticked <= px;
      if (px) ticks <= ticks + 1;
    end
  end

  function automatic logic [23:0] model_out(int k);
    int ht, vt, h, v;
    logic he, ve, hso, vso, fs;
    logic [9:0] hi;
    logic [8:0] vi;
    ht  = hv_p[k] + hf_p[k] + hs_p[k] + hb_p[k];
    vt  = vv_p[k] + vf_p[k] + vs_p[k] + vb_p[k];
    h   = ticks % ht;
    v   = (ticks / ht) % vt;
    he  = (h < hv_p[k]);
    ve  = (v < vv_p[k]);
    hi  = he ? 10'(h) : 10'd0;
    vi  = ve ? 9'(v) : 9'd0;
    hso = (h >= hv_p[k] + hf_p[k] && h < hv_p[k] + hf_p[k] + hs_p[k]) ? pol_p[k] : ~pol_p[k];
    vso = (v >= vv_p[k] + vf_p[k] && v < vv_p[k] + vf_p[k] + vs_p[k]) ? pol_p[k] : ~pol_p[k];
    fs  = ticked && (ticks > 0) && (ticks % (ht * vt) == 0);
    return {hi, vi, he, ve, hso, vso, fs};
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h (hidx,vidx,he,ve,hs,vs,fs)", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_u0", act[0], model_out(0));
      check("model_u1", act[1], model_out(1));
      check("model_u2", act[2], model_out(2));
    end
  end

  typedef struct {
    int         ticks;
    logic [9:0] hidx;
    logic [8:0] vidx;
    logic       he;
    logic       ve;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t tbl [11];

  task automatic do_reset;
    @(posedge clk); #1;
    px   = 1'b0;
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
  endtask

  task automatic tick_slow;
    px = 1'b1;
    @(posedge clk); #1;
    px = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  logic [23:0] rst_pol0;
  logic [23:0] rst_pol1;
  int          t;
  int          nfs;
  int          nvs;
  int          fs_at [$];

  initial begin
    n_vec  = 0;
    n_err  = 0;
    chk_en = 1'b0;
    px     = 1'b0;
    sclr   = 1'b0;
    #1 sclr = 1'b1;
    #20;
    rst_pol0 = {10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_pol1 = {10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    tbl[0]  = '{0,   10'd0,   9'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1,   10'd1,   9'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{639, 10'd639, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{640, 10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{655, 10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{656, 10'd0,   9'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{751, 10'd0,   9'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{752, 10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{799, 10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{800, 10'd0,   9'd1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{801, 10'd1,   9'd1, 1'b1, 1'b1, 1'b1, 1'b1};

    do_reset();
    chk_en = 1'b1;

    // Line walk at one tick per four clocks.
    t = 0;
    for (int i = 0; i < 11; i++) begin
      while (t < tbl[i].ticks) begin
        tick_slow();
        t++;
      end
      @(negedge clk);
      check($sformatf("line_u0_tick%0d", tbl[i].ticks), act[0],
            {tbl[i].hidx, tbl[i].vidx, tbl[i].he, tbl[i].ve, tbl[i].hs, tbl[i].vs, 1'b0});
      check($sformatf("line_u2_tick%0d", tbl[i].ticks), act[2],
            {tbl[i].hidx, tbl[i].vidx, tbl[i].he, tbl[i].ve, ~tbl[i].hs, ~tbl[i].vs, 1'b0});
      @(posedge clk); #1;
    end

    // Whole frames on the small raster: 16 x 13 = 208 ticks per frame.
    do_reset();
    px  = 1'b1;
    nvs = 0;
    fs_at.delete();
    for (int c = 1; c <= 624; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c <= 208 && if1.o_vsync == 1'b0) nvs++;
      if (if1.o_frame_start) begin
        fs_at.push_back(c);
        check("frame_pulse_origin", {14'd0, act[1][23:5], 1'b0} & 34'h0, 34'h0);
        check("frame_pulse_coords", {act[1][23:14], 1'b0, act[1][13:5]}, 20'd0);
      end
    end
    px = 1'b0;
    check("frame_pulse_count", 24'(fs_at.size()), 24'd3);
    if (fs_at.size() == 3) begin
      check("frame_pulse_at_1", 24'(fs_at[0]), 24'd208);
      check("frame_pulse_at_2", 24'(fs_at[1]), 24'd416);
      check("frame_pulse_at_3", 24'(fs_at[2]), 24'd624);
    end
    check("vsync_low_cycles", 24'(nvs), 24'd32);

    // Freeze at hcnt=700, then resume.
    do_reset();
    px = 1'b1;
    repeat (700) @(posedge clk);
    #1 px = 1'b0;
    repeat (1000) @(posedge clk);
    #1 px = 1'b1;
    repeat (51) @(posedge clk);
    @(negedge clk);
    check("resume_hsync_751", {23'd0, if0.o_hsync}, 24'd0);
    @(posedge clk);
    @(negedge clk);
    check("resume_hsync_752", {23'd0, if0.o_hsync}, 24'd1);
    @(posedge clk); #1;
    px = 1'b0;

    // Asynchronous reset mid-line.
    do_reset();
    px = 1'b1;
    repeat (2800) @(posedge clk);
    #2 sclr = 1'b1;
    #1;
    check("async_rst_u0", act[0], rst_pol0);
    check("async_rst_u1", act[1], rst_pol0);
    check("async_rst_u2", act[2], rst_pol1);
    @(posedge clk); #1;
    sclr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("restart_first_tick", act[0], {10'd1, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});

    // Random strobes with rare asynchronous resets, checked by the reference every cycle.
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      px   = ($urandom % 4) != 0;
      sclr = ($urandom % 3000) == 0;
    end
    @(posedge clk); #1;
    sclr = 1'b0;
    px   = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_640_480.md
# vga_sync_640_480

Raster timing generator for 640x480@60 VGA. It produces the pixel/line coordinates, visible-area enables and sync pulses that drive the colour pattern generators and the VGA connector. The block advances one pixel per `i_px_clk` strobe (25 MHz enable derived from `clk`). Its `o_hidx`/`o_vidx`/`o_haddr_enb`/`o_vaddr_enb` outputs connect directly to the matching `i_*` inputs of the pattern generators.

## Interface

Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 1'b0, active level of `o_hsync`/`o_vsync` (0 = active-low)

Ports:
- `clk`, in, 1, system clock; all state changes on its rising edge.
- `i_sclr`, in, 1, reset; asynchronous, active-high.
- `i_px_clk`, in, 1, pixel enable strobe; the raster advances only on `clk` edges where this is 1.
- `o_hidx`, out, 10, horizontal pixel index inside visible area, else 0.
- `o_vidx`, out, 9, vertical line index inside visible area, else 0.
- `o_haddr_enb`, out, 1, 1 while the horizontal count is in the visible area.
- `o_vaddr_enb`, out, 1, 1 while the vertical count is in the visible area.
- `o_hsync`, out, 1, horizontal sync at `SYNC_POL` during the hsync window.
- `o_vsync`, out, 1, vertical sync at `SYNC_POL` during the vsync window.
- `o_frame_start`, out, 1, one-`clk` pulse when the raster wraps to (0,0).

## Operation

- Internal counters:
  - `hcnt` runs 0..H_TOTAL-1, where H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800; width 10 bits.
  - `vcnt` runs 0..V_TOTAL-1, where V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 525; width 10 bits.
- On a tick (`i_px_clk`=1):
  - If `hcnt` < H_TOTAL-1, `hcnt` increments.
  - Otherwise `hcnt` becomes 0 and `vcnt` increments, wrapping V_TOTAL-1 -> 0.
  - With `i_px_clk`=0, all counters and outputs hold.
- Output decode is a function of the current (`hcnt`,`vcnt`):
  - `o_haddr_enb` = (`hcnt` < H_VISIBLE); `o_vaddr_enb` = (`vcnt` < V_VISIBLE).
  - `o_hidx` = `o_haddr_enb` ? `hcnt` : 0.
  - `o_vidx` = `o_vaddr_enb` ? `vcnt[8:0]` : 0.
  - `o_hsync` = `SYNC_POL` when H_VISIBLE+H_FP <= `hcnt` < H_VISIBLE+H_FP+H_SYNC (656..751), else `~SYNC_POL`.
  - `o_vsync` = `SYNC_POL` when V_VISIBLE+V_FP <= `vcnt` < V_VISIBLE+V_FP+V_SYNC (490..491), else `~SYNC_POL`.
- All outputs are registers (glitch-free to pads): the decode is computed from the next-state counters and loaded on the same tick, so outputs always equal the decode of the current counter registers.
- `o_frame_start` is set on the tick that moves (799,524) -> (0,0). It clears on the next `clk` edge regardless of `i_px_clk`.
- Arithmetic is unsigned. Comparisons use 10-bit counters, so there is no overflow for default parameters.

## Timing

- Reset (`i_sclr`=1, asynchronous) sets:
  - `hcnt`=0, `vcnt`=0;
  - `o_hidx`=0, `o_vidx`=0;
  - `o_haddr_enb`=1, `o_vaddr_enb`=1;
  - `o_hsync`=`o_vsync`=`~SYNC_POL`;
  - `o_frame_start`=0.
- Reset release does not itself produce `o_frame_start`.
- Latency is 0 ticks: the first tick after reset shows (1,0).
- Line period is 800 ticks; frame period is 420000 ticks. With `i_px_clk` tied high, these become `clk` cycles.
- Reset asserted mid-frame aborts immediately to the reset values; the next frame starts at (0,0) with no `o_frame_start` for the aborted frame.
- Simultaneous `i_sclr`=1 and `i_px_clk`=1: reset wins.

## Test plan

- Reset, then 0 ticks -> `o_hidx`=0, `o_vidx`=0, both enables 1, `o_hsync`=`o_vsync`=1, `o_frame_start`=0.
- 1 tick per 4 `clk` (25 MHz from 100 MHz) for 800 ticks:
  - `o_haddr_enb` falls at `hcnt`=640 and `o_hidx` becomes 0.
  - `o_hsync`=0 exactly for ticks 656..751.
  - At tick 800, `hcnt`=0 and `o_vidx`=1.
  - Outputs never change on non-tick cycles.
- `i_px_clk` tied high for 420000 cycles:
  - `o_vaddr_enb`=0 from line 480.
  - `o_vsync`=0 for lines 490-491 only (1600 cycles).
  - `o_frame_start` is a single-cycle pulse at cycle 420000, with `o_hidx`=`o_vidx`=0.
- `i_px_clk` held low for 1000 cycles at `hcnt`=700 -> all outputs frozen; on resuming, the counter continues at 701.
- `i_sclr` pulsed asynchronously (mid-cycle) at line 300, pixel 400 -> outputs take reset values before the next `clk` edge; no `o_frame_start`; the raster restarts at (0,0).
- `SYNC_POL`=1 rerun of the line test -> `o_hsync`=1 only for ticks 656..751; reset value 0.
